proc_core_param: RTL and testbench

PROC_CORE_PARAM -- requirements
Module: proc_core_param

---
 rtl/proc_core_param.sv | 159 +++++++++++++++
 tb/tb_proc_core_param.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/proc_core_param.sv
// Multi-cycle accumulator-less register machine: fetch/decode/execute FSM over a
// synchronous instruction memory, with a small ALU, conditional jump and debug port.
module proc_core_param #(
    parameter int DATA_W = 16,
    parameter int NREG   = 16,
    parameter int PC_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run,
    output logic [PC_W-1:0]         imem_addr,
    input  logic [DATA_W-1:0]       imem_data,
    input  logic [$clog2(NREG)-1:0] dbg_sel,
    output logic [DATA_W-1:0]       dbg_data,
    output logic                    done,
    output logic                    halted,
    output logic                    zero_flag,
    output logic                    carry_flag,
    output logic                    illegal
);
    localparam int RA_W = $clog2(NREG);
    localparam int IR_W = 4 + 2 * RA_W;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LDI  = 4'd1;
    localparam logic [3:0] OP_MOV  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_JZ   = 4'd5;
    localparam logic [3:0] OP_HALT = 4'd6;

    generate
        if (NREG < 2 || (1 << RA_W) != NREG) begin : g_bad_nreg
            $error("proc_core_param: NREG must be a power of two >= 2");
        end
        if (DATA_W < IR_W) begin : g_bad_width
            $error("proc_core_param: DATA_W must be >= 4 + 2*log2(NREG)");
        end
        if (PC_W > DATA_W) begin : g_bad_pc
            $error("proc_core_param: PC_W must not exceed DATA_W");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_FETCH, S_WAIT, S_DECODE, S_FETCH2, S_WAIT2, S_EXEC, S_HALT
    } state_t;

    state_t                       state, state_nx;
    logic [PC_W-1:0]              pc, pc_nx;
    logic [IR_W-1:0]              ir;
    logic [DATA_W-1:0]            opnd;
    logic [NREG-1:0][DATA_W-1:0]  regs;
    logic                         stall_q;

    logic [3:0]                   op, dec_op;
    logic [RA_W-1:0]              rx, ry;
    logic [DATA_W-1:0]            a, b;
    logic [DATA_W:0]              sum, diff;

    assign op     = ir[IR_W-1 -: 4];
    assign rx     = ir[IR_W-5 -: RA_W];
    assign ry     = ir[IR_W-5-RA_W -: RA_W];
    assign dec_op = imem_data[DATA_W-1 -: 4];

    // Operands are read before any write this cycle, so rx==ry sees the old value.
    assign a    = regs[rx];
    assign b    = regs[ry];
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    assign dbg_data = regs[dbg_sel];

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        case (state)
            S_FETCH:  state_nx = S_WAIT;
            // Coming out of a stall the pending word is treated as lost.
            S_WAIT:   state_nx = stall_q ? S_FETCH : S_DECODE;
            S_DECODE: begin
                pc_nx    = pc + 1'b1;
                state_nx = (dec_op == OP_LDI || dec_op == OP_JZ) ? S_FETCH2 : S_EXEC;
            end
            S_FETCH2: state_nx = S_WAIT2;
            S_WAIT2: begin
                if (stall_q) begin
                    state_nx = S_FETCH2;
                end else begin
                    pc_nx    = pc + 1'b1;
                    state_nx = S_EXEC;
                end
            end
            S_EXEC: begin
                if (op == OP_JZ && a == '0)
                    pc_nx = opnd[PC_W-1:0];
                state_nx = (op == OP_HALT) ? S_HALT : S_FETCH;
            end
            S_HALT:   state_nx = S_HALT;
            default:  state_nx = S_FETCH;
        endcase
        if (!run) begin
            state_nx = state;
            pc_nx    = pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_FETCH;
            pc         <= '0;
            imem_addr  <= '0;
            ir         <= '0;
            opnd       <= '0;
            regs       <= '0;
            stall_q    <= 1'b0;
            done       <= 1'b0;
            halted     <= 1'b0;
            zero_flag  <= 1'b0;
            carry_flag <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            done    <= 1'b0;
            stall_q <= ~run;
            if (run) begin
                state <= state_nx;
                pc    <= pc_nx;
                // The address register is loaded on entry to a fetch state so the
                // memory word is available from the following cycle onward.
                if (state_nx == S_FETCH || state_nx == S_FETCH2)
                    imem_addr <= pc_nx;
                case (state)
                    S_DECODE: ir <= imem_data[DATA_W-1 -: IR_W];
                    S_WAIT2:  if (!stall_q) opnd <= imem_data;
                    S_EXEC: begin
                        done <= (op != OP_HALT);
                        case (op)
                            OP_NOP, OP_JZ: ;
                            OP_LDI: regs[rx] <= opnd;
                            OP_MOV: regs[rx] <= b;
                            OP_ADD: begin
                                regs[rx]   <= sum[DATA_W-1:0];
                                zero_flag  <= (sum[DATA_W-1:0] == '0);
                                carry_flag <= sum[DATA_W];
                            end
                            OP_SUB: begin
                                regs[rx]   <= diff[DATA_W-1:0];
                                zero_flag  <= (diff[DATA_W-1:0] == '0);
                                carry_flag <= diff[DATA_W];
                            end
                            OP_HALT: halted <= 1'b1;
                            default: illegal <= 1'b1;
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_proc_core_param.sv
// Directed-program bench for proc_core_param: default instance plus a narrow
// (NREG=4, DATA_W=12, PC_W=6) instance running the same basic program.
module tb_proc_core_param;
    logic        clk = 1'b0;
    logic        rst, run, poison;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic [3:0]  dbg_sel;
    logic [15:0] dbg_data;
    logic        done, halted, zero_flag, carry_flag, illegal;

    logic [5:0]  imem_addr2;
    logic [11:0] imem_data2;
    logic [1:0]  dbg_sel2;
    logic [11:0] dbg_data2;
    logic        done2, halted2, zero_flag2, carry_flag2, illegal2;

    logic [15:0] mem  [0:255];
    logic [11:0] mem2 [0:63];

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt, done_cnt2;
    int cyc;
    logic [15:0] v;

    always #5 clk = ~clk;

    proc_core_param u_dut (
        .clk(clk), .rst(rst), .run(run),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data),
        .done(done), .halted(halted), .zero_flag(zero_flag),
        .carry_flag(carry_flag), .illegal(illegal)
    );

    proc_core_param #(.DATA_W(12), .NREG(4), .PC_W(6)) u_small (
        .clk(clk), .rst(rst), .run(run),
        .imem_addr(imem_addr2), .imem_data(imem_data2),
        .dbg_sel(dbg_sel2), .dbg_data(dbg_data2),
        .done(done2), .halted(halted2), .zero_flag(zero_flag2),
        .carry_flag(carry_flag2), .illegal(illegal2)
    );

    // Synchronous memories; poison corrupts the word read while the core is stalled.
    always @(posedge clk) imem_data  <= poison ? 16'hDEAD : mem[imem_addr];
    always @(posedge clk) imem_data2 <= mem2[imem_addr2];

    always @(negedge clk) begin
        if (done)  done_cnt  = done_cnt + 1;
        if (done2) done_cnt2 = done_cnt2 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic rd(input int r, output logic [15:0] val);
        dbg_sel = r[3:0];
        #1;
        val = dbg_data;
    endtask

    task automatic clr_mem;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        run = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_addr", imem_addr, 0);
        chk("rst_done", done, 0);
        chk("rst_halted", halted, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_flags", {zero_flag, carry_flag}, 0);
        rd(1, v);
        chk("rst_r1", v, 0);
        done_cnt  = 0;
        done_cnt2 = 0;
        rst = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < budget);
        if (!done) chk("done_timeout", done, 1);
    endtask

    task automatic wait_halt(input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("halt_seen", halted, 1);
    endtask

    initial begin
        rst = 1'b1; run = 1'b1; poison = 1'b0; dbg_sel = '0; dbg_sel2 = '0;
        done_cnt = 0; done_cnt2 = 0;

        // Basic program on both widths: r1=5+3
        clr_mem();
        mem[0] = 16'h1100; mem[1] = 16'h0005;
        mem[2] = 16'h1200; mem[3] = 16'h0003;
        mem[4] = 16'h3120; mem[5] = 16'h6000;
        for (int i = 0; i < 64; i++) mem2[i] = 12'h000;
        mem2[0] = 12'h140; mem2[1] = 12'h005;
        mem2[2] = 12'h180; mem2[3] = 12'h003;
        mem2[4] = 12'h360; mem2[5] = 12'h600;
        do_reset();
        wait_done(20, cyc); chk("lat_ldi", cyc, 6);
        wait_done(20, cyc); chk("lat_ldi_b", cyc, 6);
        wait_done(20, cyc); chk("lat_add", cyc, 4);
        wait_halt(20);
        repeat (5) @(negedge clk);
        run = 1'b0; repeat (2) @(negedge clk); run = 1'b1;
        repeat (3) @(negedge clk);
        rd(1, v); chk("p1_r1", v, 8);
        rd(2, v); chk("p1_r2", v, 3);
        chk("p1_flags", {zero_flag, carry_flag}, 0);
        chk("p1_dones", done_cnt, 3);
        chk("p1_halted", halted, 1);
        chk("p1_no_fetch", imem_addr, 5);
        dbg_sel2 = 2'd1; #1;
        chk("s_r1", dbg_data2, 8);
        chk("s_flags", {zero_flag2, carry_flag2}, 0);
        chk("s_dones", done_cnt2, 3);
        chk("s_halted", halted2, 1);

        // Overflow/borrow, then rx==ry cases
        clr_mem();
        mem[0] = 16'h1100; mem[1] = 16'hFFFF;
        mem[2] = 16'h1200; mem[3] = 16'h0001;
        mem[4] = 16'h3120; mem[5] = 16'h4120;
        mem[6] = 16'h3220; mem[7] = 16'h2520;
        mem[8] = 16'h4550; mem[9] = 16'h6000;
        do_reset();
        repeat (3) wait_done(20, cyc);
        rd(1, v); chk("add_wrap_r1", v, 16'h0000);
        chk("add_wrap_zc", {zero_flag, carry_flag}, 2'b11);
        wait_done(20, cyc);
        rd(1, v); chk("sub_borrow_r1", v, 16'hFFFF);
        chk("sub_borrow_zc", {zero_flag, carry_flag}, 2'b01);
        wait_halt(40);
        rd(2, v); chk("add_self_r2", v, 2);
        rd(5, v); chk("sub_self_r5", v, 0);
        chk("sub_self_zc", {zero_flag, carry_flag}, 2'b10);

        // JZ taken then not taken
        clr_mem();
        mem[0]    = 16'h1300; mem[1]    = 16'h0000;
        mem[2]    = 16'h5300; mem[3]    = 16'h0010;
        mem[4]    = 16'h1600; mem[5]    = 16'h0BAD;
        mem[8'h10] = 16'h1400; mem[8'h11] = 16'h0007;
        mem[8'h12] = 16'h2340;
        mem[8'h13] = 16'h5300; mem[8'h14] = 16'h0030;
        mem[8'h15] = 16'h6000;
        mem[8'h30] = 16'h1600; mem[8'h31] = 16'h0BAD;
        mem[8'h32] = 16'h6000;
        do_reset();
        wait_done(20, cyc);
        wait_done(20, cyc); chk("jz_lat", cyc, 6);
        chk("jz_taken_addr", imem_addr, 8'h10);
        repeat (3) wait_done(20, cyc);
        chk("jz_not_taken_addr", imem_addr, 8'h15);
        wait_halt(20);
        rd(6, v); chk("jz_r6", v, 0);
        rd(3, v); chk("jz_r3", v, 7);

        // Undefined opcode
        clr_mem();
        mem[0] = 16'h1500; mem[1] = 16'h1234;
        mem[2] = 16'h9550; mem[3] = 16'h0000; mem[4] = 16'h6000;
        do_reset();
        wait_done(20, cyc);
        chk("ill_before", illegal, 0);
        wait_done(20, cyc); chk("ill_lat", cyc, 4);
        chk("ill_set", illegal, 1);
        rd(5, v); chk("ill_r5", v, 16'h1234);
        wait_done(20, cyc);
        chk("ill_sticky", illegal, 1);
        chk("ill_flags", {zero_flag, carry_flag}, 0);
        wait_halt(20);

        // Stall in WAIT2 of an LDI forces an operand re-fetch
        clr_mem();
        mem[0] = 16'h1700; mem[1] = 16'h5A5A; mem[2] = 16'h6000;
        do_reset();
        repeat (4) @(negedge clk);
        run = 1'b0; poison = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_done", done, 0);
            chk("stall_addr", imem_addr, 1);
        end
        run = 1'b1; poison = 1'b0;
        wait_done(20, cyc); chk("refetch_lat", cyc, 4);
        wait_halt(20);
        rd(7, v); chk("refetch_r7", v, 16'h5A5A);
        chk("refetch_dones", done_cnt, 1);

        // Reset during EXEC of ADD r8,r1
        clr_mem();
        mem[0] = 16'h1100; mem[1] = 16'h0005;
        mem[2] = 16'h3810; mem[3] = 16'h6000;
        do_reset();
        wait_done(20, cyc);
        repeat (3) @(negedge clk);
        rst = 1'b1; #1;
        rd(8, v); chk("midrst_r8", v, 0);
        chk("midrst_addr", imem_addr, 0);
        chk("midrst_done", done, 0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("midrst_r8_after", dbg_data, 0);
        chk("midrst_fetch0", imem_addr, 0);
        wait_halt(40);
        rd(8, v); chk("rerun_r8", v, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
